// File: rtl/motor_sequencer.sv
// motor_sequencer: two-channel H-bridge PWM sequencer driven by steering codes, with reversal dwell and halt.
// Optional feature macro SOFT_START_EN: applied duty ramps towards target by RAMP_STEP per PWM period.
module motor_sequencer #(
    parameter int PWM_PERIOD   = 1000,
    parameter int DUTY_FULL    = 900,
    parameter int DUTY_VEER    = 600,
    parameter int DUTY_HARD    = 300,
    parameter int DWELL_CYCLES = 5_000_000,
    parameter int RAMP_STEP    = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dir_code,
    input  logic       dir_req,
    input  logic       run_en,
    output logic       direction,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       mdir_l,
    output logic       mdir_r,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        DWELL = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [3:0] CODE_PROCEED  = 4'b0000;
    localparam logic [3:0] CODE_VEER_R   = 4'b1001;
    localparam logic [3:0] CODE_HARD_R   = 4'b1010;
    localparam logic [3:0] CODE_NINETY_R = 4'b1011;
    localparam logic [3:0] CODE_VEER_L   = 4'b0101;
    localparam logic [3:0] CODE_HARD_L   = 4'b0110;
    localparam logic [3:0] CODE_NINETY_L = 4'b0111;
    localparam logic [3:0] CODE_STOP     = 4'b1111;

    localparam logic [15:0] PWM_LAST = 16'(PWM_PERIOD - 1);
    localparam logic [15:0] FULL     = 16'(DUTY_FULL);
    localparam logic [15:0] VEER     = (DUTY_VEER > DUTY_FULL) ? FULL : 16'(DUTY_VEER);
    localparam logic [15:0] HARD     = (DUTY_HARD > DUTY_FULL) ? FULL : 16'(DUTY_HARD);

`ifdef SOFT_START_EN
    localparam bit SOFT_START = 1'b1;
`else
    localparam bit SOFT_START = 1'b0;
`endif
    // With soft start off the step is effectively unbounded, so applied duty lands on target at once.
    localparam logic [15:0] RAMP = SOFT_START ? 16'(RAMP_STEP) : 16'hFFFF;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_done;
    logic          force_off;
    logic          boundary;
    logic          code_go;
    logic [15:0]   pwm_cnt;
    logic [15:0]   duty_l;
    logic [15:0]   duty_r;
    logic [15:0]   next_l;
    logic [15:0]   next_r;
    logic [15:0]   fwd_l;
    logic [15:0]   fwd_r;
    logic [15:0]   tgt_l;
    logic [15:0]   tgt_r;
    logic          fwd_ml;
    logic          fwd_mr;
    logic          tgt_ml;
    logic          tgt_mr;

    // Rising duties climb by at most RAMP; falling duties snap to target. Never exceeds target.
    function automatic logic [15:0] ramp(input logic [15:0] cur, input logic [15:0] tgt);
        logic [15:0] gap;
        gap = tgt - cur;
        if (cur >= tgt)
            return tgt;
        return (gap < RAMP) ? tgt : cur + RAMP;
    endfunction

    assign boundary = (pwm_cnt == PWM_LAST);
    assign state    = state_q;
    assign next_l   = ramp(duty_l, tgt_l);
    assign next_r   = ramp(duty_r, tgt_r);

    always_comb begin
        fwd_l   = '0;
        fwd_r   = '0;
        fwd_ml  = 1'b1;
        fwd_mr  = 1'b1;
        code_go = 1'b1;
        case (dir_code)
            CODE_PROCEED:  begin fwd_l = FULL; fwd_r = FULL; end
            CODE_VEER_R:   begin fwd_l = FULL; fwd_r = VEER; end
            CODE_HARD_R:   begin fwd_l = FULL; fwd_r = HARD; end
            CODE_NINETY_R: begin fwd_l = FULL; fwd_r = FULL; fwd_mr = 1'b0; end
            CODE_VEER_L:   begin fwd_l = VEER; fwd_r = FULL; end
            CODE_HARD_L:   begin fwd_l = HARD; fwd_r = FULL; end
            CODE_NINETY_L: begin fwd_l = FULL; fwd_r = FULL; fwd_ml = 1'b0; end
            CODE_STOP:     code_go = 1'b0;
            default:       code_go = 1'b0;
        endcase
    end

    // Travelling backwards the robot's left is the drive table's right, and both wheels flip polarity.
    always_comb begin
        tgt_l  = '0;
        tgt_r  = '0;
        tgt_ml = direction;
        tgt_mr = direction;
        if (state_q == DRIVE && code_go) begin
            if (direction) begin
                tgt_l  = fwd_l;
                tgt_r  = fwd_r;
                tgt_ml = fwd_ml;
                tgt_mr = fwd_mr;
            end else begin
                tgt_l  = fwd_r;
                tgt_r  = fwd_l;
                tgt_ml = ~fwd_ml;
                tgt_mr = ~fwd_mr;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dwell_done = 1'b0;
        if (!run_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = DRIVE;
                DRIVE: begin
                    if (dir_req != direction)
                        state_d = DWELL;
                    else if (!code_go)
                        state_d = HALT;
                end
                DWELL: begin
                    if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
                        state_d    = DRIVE;
                        dwell_done = 1'b1;
                    end
                end
                HALT:  if (code_go) state_d = DRIVE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Entering or staying in DWELL, or losing run_en, kills drive without waiting for a boundary.
    assign force_off = (state_d == DWELL) || !run_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            direction <= 1'b1;
            dwell_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (dwell_done)
                direction <= dir_req;
            if (state_q == DWELL && state_d == DWELL)
                dwell_cnt <= dwell_cnt + DW'(1);
            else
                dwell_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty_l  <= '0;
            duty_r  <= '0;
            pwm_l   <= 1'b0;
            pwm_r   <= 1'b0;
            mdir_l  <= 1'b1;
            mdir_r  <= 1'b1;
        end else begin
            pwm_cnt <= boundary ? 16'd0 : pwm_cnt + 16'd1;
            if (force_off) begin
                duty_l <= '0;
                duty_r <= '0;
            end else if (boundary) begin
                duty_l <= next_l;
                duty_r <= next_r;
            end
            if (boundary) begin
                mdir_l <= tgt_ml;
                mdir_r <= tgt_mr;
            end
            pwm_l <= !force_off && (pwm_cnt < duty_l);
            pwm_r <= !force_off && (pwm_cnt < duty_r);
        end
    end

endmodule

// File: tb/tb_motor_sequencer.sv
// tb_motor_sequencer: directed stimulus against a table-driven behavioural model of motor_sequencer,
// compared every cycle, plus hand-computed duty-window and state expectations.
module tb_motor_sequencer;

    localparam int P     = 10;
    localparam int FULL  = 9;
    localparam int VEER  = 6;
    localparam int HARD  = 3;
    localparam int DWELL = 20;
    localparam int STEP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dir_code;
    logic       dir_req;
    logic       run_en;
    logic       direction;
    logic       pwm_l;
    logic       pwm_r;
    logic       mdir_l;
    logic       mdir_r;
    logic [1:0] state;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    int tab_l[16];
    int tab_r[16];
    bit tab_ml[16];
    bit tab_mr[16];
    bit tab_go[16];

    int m_t;
    int m_mode;
    int m_left;
    int m_appl;
    int m_appr;
    bit m_dir;
    bit m_pl;
    bit m_pr;
    bit m_ml;
    bit m_mr;

    motor_sequencer #(
        .PWM_PERIOD  (P),
        .DUTY_FULL   (FULL),
        .DUTY_VEER   (VEER),
        .DUTY_HARD   (HARD),
        .DWELL_CYCLES(DWELL),
        .RAMP_STEP   (STEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dir_code (dir_code),
        .dir_req  (dir_req),
        .run_en   (run_en),
        .direction(direction),
        .pwm_l    (pwm_l),
        .pwm_r    (pwm_r),
        .mdir_l   (mdir_l),
        .mdir_r   (mdir_r),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code, input logic req, input logic run, input logic r);
        dir_code = code;
        dir_req  = req;
        run_en   = run;
        rst      = r;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts high cycles over a window on both the DUT and the model, pinning each to hand values.
    task automatic checkWindow(input string name, input int n, input int el, input int er);
        int hl = 0, hr = 0, ml = 0, mr = 0;
        repeat (n) begin
            @(negedge clk);
            hl += int'(pwm_l);
            hr += int'(pwm_r);
            ml += int'(m_pl);
            mr += int'(m_pr);
        end
        checkOutput({name, "_dut_l"}, 16'(hl), 16'(el));
        checkOutput({name, "_dut_r"}, 16'(hr), 16'(er));
        checkOutput({name, "_model_l"}, 16'(ml), 16'(el));
        checkOutput({name, "_model_r"}, 16'(mr), 16'(er));
    endtask

    function automatic int rampTo(input int cur, input int tgt);
`ifdef SOFT_START_EN
        if (cur >= tgt) return tgt;
        return (tgt - cur < STEP) ? tgt : cur + STEP;
`else
        return tgt + 0 * cur;
`endif
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            tab_l[i] = 0; tab_r[i] = 0; tab_ml[i] = 1'b1; tab_mr[i] = 1'b1; tab_go[i] = 1'b0;
        end
        tab_go[4'b0000] = 1; tab_l[4'b0000] = FULL; tab_r[4'b0000] = FULL;
        tab_go[4'b1001] = 1; tab_l[4'b1001] = FULL; tab_r[4'b1001] = VEER;
        tab_go[4'b1010] = 1; tab_l[4'b1010] = FULL; tab_r[4'b1010] = HARD;
        tab_go[4'b1011] = 1; tab_l[4'b1011] = FULL; tab_r[4'b1011] = FULL; tab_mr[4'b1011] = 1'b0;
        tab_go[4'b0101] = 1; tab_l[4'b0101] = VEER; tab_r[4'b0101] = FULL;
        tab_go[4'b0110] = 1; tab_l[4'b0110] = HARD; tab_r[4'b0110] = FULL;
        tab_go[4'b0111] = 1; tab_l[4'b0111] = FULL; tab_r[4'b0111] = FULL; tab_ml[4'b0111] = 1'b0;
    end

    // Behavioural model: mode numbers are the state output codes, dwell is a countdown of cycles left.
    initial begin
        int tl, tr, nmode, ph;
        bit tml, tmr, kill, bnd, ndir;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_t = 0; m_mode = 0; m_dir = 1'b1; m_left = 0; m_appl = 0; m_appr = 0;
                m_pl = 1'b0; m_pr = 1'b0; m_ml = 1'b1; m_mr = 1'b1;
            end else begin
                ph  = m_t % P;
                bnd = (ph == P - 1);
                if (m_mode == 1 && tab_go[dir_code]) begin
                    if (m_dir) begin
                        tl = tab_l[dir_code]; tr = tab_r[dir_code];
                        tml = tab_ml[dir_code]; tmr = tab_mr[dir_code];
                    end else begin
                        tl = tab_r[dir_code]; tr = tab_l[dir_code];
                        tml = !tab_ml[dir_code]; tmr = !tab_mr[dir_code];
                    end
                end else begin
                    tl = 0; tr = 0; tml = m_dir; tmr = m_dir;
                end
                nmode = m_mode; ndir = m_dir; kill = 1'b0;
                if (!run_en) begin
                    nmode = 0; kill = 1'b1;
                end else begin
                    case (m_mode)
                        0: nmode = 1;
                        1: begin
                            if (dir_req != m_dir) begin nmode = 2; m_left = DWELL; kill = 1'b1; end
                            else if (!tab_go[dir_code]) nmode = 3;
                        end
                        2: begin
                            m_left--;
                            if (m_left == 0) begin nmode = 1; ndir = dir_req; end
                            else kill = 1'b1;
                        end
                        default: if (tab_go[dir_code]) nmode = 1;
                    endcase
                end
                m_pl = !kill && (ph < m_appl);
                m_pr = !kill && (ph < m_appr);
                if (kill) begin
                    m_appl = 0; m_appr = 0;
                end else if (bnd) begin
                    m_appl = rampTo(m_appl, tl); m_appr = rampTo(m_appr, tr);
                end
                if (bnd) begin m_ml = tml; m_mr = tmr; end
                m_t++;
                m_mode = nmode;
                m_dir  = ndir;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("cyc_state", {14'b0, state}, 16'(m_mode));
                checkOutput("cyc_direction", {15'b0, direction}, {15'b0, m_dir});
                checkOutput("cyc_pwm_l", {15'b0, pwm_l}, {15'b0, m_pl});
                checkOutput("cyc_pwm_r", {15'b0, pwm_r}, {15'b0, m_pr});
                checkOutput("cyc_mdir_l", {15'b0, mdir_l}, {15'b0, m_ml});
                checkOutput("cyc_mdir_r", {15'b0, mdir_r}, {15'b0, m_mr});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
        stepCycles(3);
        check_en = 1'b1;
        checkOutput("rst_state", {14'b0, state}, 16'd0);
        checkOutput("rst_direction", {15'b0, direction}, 16'd1);
        checkOutput("rst_pwm_l", {15'b0, pwm_l}, 16'd0);
        checkOutput("rst_pwm_r", {15'b0, pwm_r}, 16'd0);
        checkOutput("rst_mdir_l", {15'b0, mdir_l}, 16'd1);
        checkOutput("rst_mdir_r", {15'b0, mdir_r}, 16'd1);

        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("start_state", {14'b0, state}, 16'd1);
        stepCycles(9);
`ifdef SOFT_START_EN
        checkWindow("ramp_p1", P, 3, 3);
        checkWindow("ramp_p2", P, 6, 6);
        checkWindow("ramp_p3", P, 9, 9);
`else
        checkWindow("proceed_p1", P, 9, 9);
        checkWindow("proceed_p2", P, 9, 9);
        checkWindow("proceed_p3", P, 9, 9);
`endif
        checkOutput("proceed_mdir_l", {15'b0, mdir_l}, 16'd1);
        checkOutput("proceed_mdir_r", {15'b0, mdir_r}, 16'd1);

        stepCycles(4);
        applyStimulus(4'b1010, 1'b1, 1'b1, 1'b0);
        stepCycles(35);
        checkWindow("hard_right", P, 9, 3);

        applyStimulus(4'b0111, 1'b1, 1'b1, 1'b0);
        stepCycles(35);
        checkWindow("ninety_left", P, 9, 9);
        checkOutput("ninety_left_mdir_l", {15'b0, mdir_l}, 16'd0);
        checkOutput("ninety_left_mdir_r", {15'b0, mdir_r}, 16'd1);

        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("dwell_entry", {14'b0, state}, 16'd2);
        checkWindow("dwell_quiet", DWELL - 1, 0, 0);
        checkOutput("dwell_last_cycle", {14'b0, state}, 16'd2);
        stepCycles(1);
        checkOutput("dwell_exit_state", {14'b0, state}, 16'd1);
        checkOutput("dwell_exit_direction", {15'b0, direction}, 16'd0);
        applyStimulus(4'b1001, 1'b0, 1'b1, 1'b0);
        stepCycles(35);
        checkWindow("back_veer_right", P, 6, 9);
        checkOutput("back_mdir_l", {15'b0, mdir_l}, 16'd0);
        checkOutput("back_mdir_r", {15'b0, mdir_r}, 16'd0);

        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("halt_state", {14'b0, state}, 16'd3);
        stepCycles(12);
        checkWindow("halt_quiet", P, 0, 0);
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
        stepCycles(3);
        checkOutput("halt_ignores_req", {14'b0, state}, 16'd3);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("halt_resume", {14'b0, state}, 16'd1);
        stepCycles(1);
        checkOutput("resume_reverse", {14'b0, state}, 16'd2);
        stepCycles(5);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("abort_state", {14'b0, state}, 16'd0);
        checkOutput("abort_direction", {15'b0, direction}, 16'd0);

        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepCycles(35);
        applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("stop_vs_reverse", {14'b0, state}, 16'd2);
        stepCycles(5);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepCycles(30);
        checkOutput("revert_state", {14'b0, state}, 16'd1);
        checkOutput("revert_direction", {15'b0, direction}, 16'd0);

        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        stepCycles(5);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1);
        stepCycles(1);
        checkOutput("rst_dwell_state", {14'b0, state}, 16'd0);
        checkOutput("rst_dwell_direction", {15'b0, direction}, 16'd1);

        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        stepCycles(35);
        seen = 1'b0;
        for (int i = 0; i < 2 * P && !seen; i++) begin
            if (pwm_l === 1'b1) seen = 1'b1;
            else stepCycles(1);
        end
        checkOutput("pwm_high_seen", {15'b0, seen}, 16'd1);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1);
        stepCycles(1);
        checkOutput("rst_period_pwm_l", {15'b0, pwm_l}, 16'd0);
        checkOutput("rst_period_pwm_r", {15'b0, pwm_r}, 16'd0);

        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
        stepCycles(12);
        for (int c = 0; c < 16; c++) begin
            applyStimulus(4'(c), 1'b1, 1'b1, 1'b0);
            stepCycles(22);
        end
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepCycles(25);
        for (int c = 0; c < 16; c++) begin
            applyStimulus(4'(c), 1'b0, 1'b1, 1'b0);
            stepCycles(22);
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
